// File: rtl/de_write_port_if.sv
// Drawing-engine write request port plus frame-store drain port, bundled.
// slave = the responder (de_write_port); master = the initiator/memory side driving it.
interface de_write_port_if;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_data;
  logic        mem_req;
  logic        mem_ack;
  logic [17:0] mem_addr;
  logic [3:0]  mem_nbyte;
  logic [31:0] mem_data;
  logic        idle;

  modport slave (
    input  de_req, de_addr, de_nbyte, de_data, mem_ack,
    output de_ack, mem_req, mem_addr, mem_nbyte, mem_data, idle
  );

  modport master (
    output de_req, de_addr, de_nbyte, de_data, mem_ack,
    input  de_ack, mem_req, mem_addr, mem_nbyte, mem_data, idle
  );
endinterface

// File: rtl/de_write_port.sv
// Byte-masked word write queue between drawers and the frame store; merges same-word writes into the tail.
// Latency: accept at edge n -> mem_req in cycle n+1; de_ack drops only when all DEPTH entries are occupied.
module de_write_port #(
  parameter int DEPTH = 4,
  parameter bit MERGE = 1'b1
) (
  input logic           clk,
  input logic           rst,
  de_write_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [17:0] addr_q  [DEPTH];
  logic [3:0]  nbyte_q [DEPTH];
  logic [31:0] data_q  [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count;

  logic        ack;
  logic        accept;
  logic        discard;
  logic        merge;
  logic        push;
  logic        pop;
  logic [31:0] merged_data;

  assign tail_ptr = wr_ptr - AW'(1);
  assign ack      = (count != FULL_CNT);

  // Merging needs count >= 2 so the head, which mem_* is presenting, is never rewritten.
  always_comb begin
    accept  = bus.de_req && ack;
    discard = accept && (bus.de_nbyte == 4'hF);
    merge   = MERGE && accept && !discard && (count >= CW'(2)) &&
              (bus.de_addr == addr_q[tail_ptr]);
    push    = accept && !discard && !merge;
    pop     = (count != '0) && bus.mem_ack;
  end

  always_comb begin
    merged_data = data_q[tail_ptr];
    for (int i = 0; i < 4; i++) begin
      if (!bus.de_nbyte[i]) merged_data[8*i +: 8] = bus.de_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        nbyte_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr]  <= bus.de_addr;
        nbyte_q[wr_ptr] <= bus.de_nbyte;
        data_q[wr_ptr]  <= bus.de_data;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (merge) begin
        nbyte_q[tail_ptr] <= nbyte_q[tail_ptr] & bus.de_nbyte;
        data_q[tail_ptr]  <= merged_data;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.de_ack    = ack;
  assign bus.mem_req   = (count != '0);
  assign bus.idle      = (count == '0);
  assign bus.mem_addr  = addr_q[rd_ptr];
  assign bus.mem_nbyte = nbyte_q[rd_ptr];
  assign bus.mem_data  = data_q[rd_ptr];
endmodule

// File: doc/de_write_port.md
# de_write_port

Memory-side responder for the drawing-engine pixel write interface. Accepts byte-masked word writes on the `de_*` request/acknowledge port and queues them in a small FIFO. Youngest queued writes to the same word are merged, and the queue drains one word per handshake to the frame-store memory controller on the `mem_*` port. It sits between any `de_*` initiator (line/rectangle drawers) and the frame-store arbiter, decoupling drawer throughput from memory stalls.

## Interface

- DEPTH, 4, FIFO entries; power of two, ≥2
- MERGE, 1, 1 = enable same-word write merging into the tail entry; 0 = never merge
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- de_req  input  1  initiator has a write pending
- de_ack  output  1  responder can accept; transfer occurs on an edge where `de_req && de_ack`
- de_addr  input  18  word address
- de_nbyte  input  4  byte-lane enables, active-low (bit i low = write byte i)
- de_data  input  32  write data, lane i = bits 8i+7:8i
- mem_req  output  1  head entry valid, write pending to memory
- mem_ack  input  1  memory accepted head entry this edge
- mem_addr  output  18  head entry word address
- mem_nbyte  output  4  head entry byte enables, active-low
- mem_data  output  32  head entry data
- idle  output  1  FIFO empty (`count == 0`)

## Operation

- State: DEPTH entries {addr, nbyte, data}, read pointer, write pointer, count (0..DEPTH).
- de_ack = (count != DEPTH). It is a function of registered state only and never depends combinationally on de_req; initiators may derive de_req from de_ack.
- Accept (edge with de_req && de_ack):
  - de_nbyte == 4'b1111 (no lanes): acknowledged and discarded, no state change.
  - Merge: when MERGE=1, count ≥ 2, and de_addr == tail.addr, update the tail in place. tail.nbyte ← tail.nbyte & de_nbyte. Each lane with de_nbyte[i]=0 takes the de_data lane; other lanes keep their value. Count is unchanged by the merge.
  - Otherwise push a new entry at the write pointer, and the write pointer increments.
  - Merge never targets the head entry (count==1 → always push), so data on mem_* is stable while mem_req is high.
- Pop: on an edge with mem_req && mem_ack, the read pointer increments. mem_ack with mem_req low is ignored.
- Simultaneous push + pop: count unchanged, both pointers advance. Simultaneous merge + pop at count==2: the merged tail becomes the head and its merged contents are presented next cycle.
- Count: +1 on push-only, −1 on pop-only, 0 otherwise. Pointers wrap modulo DEPTH.
- mem_req = (count != 0). mem_addr/nbyte/data = entry at the read pointer.
- Full (count==DEPTH): de_ack low. A pop on that edge makes de_ack high the next cycle. A push is not accepted on the same edge as the pop.
- Empty: mem_req low, idle high, mem_* show the stale entry at the read pointer.
- Reset (asynchronous, any time incl. mid-burst): pointers and count ← 0, all entries ← 0. Queued writes are lost.

## Timing

- Reset values: de_ack=1, mem_req=0, mem_addr=0, mem_nbyte=4'b0000 (storage reset to 0), mem_data=0, idle=1.
- Latency: accept at edge n → mem_req high during cycle n+1 (FIFO previously empty).
- Throughput: one accept and one pop per cycle sustained. Back-to-back de_ack with no bubble while count < DEPTH.
- mem_* outputs change only on edges where a pop occurs, or on the edge where the first push into an empty FIFO occurs.
- Per cycle: at most one write-side operation (push, merge or discard) and at most one pop.
- No combinational path from de_* inputs to any output, or from mem_ack to any output.

## Test plan

- Reset then single write: addr 0x00010, nbyte 4'b1110, data 0x5A5A5A5A, mem_ack held low. Required: de_ack=1 after reset; mem_req=1 one cycle after accept with matching mem_* values; mem_ack pulse → idle=1 next cycle.
- Fill/backpressure: mem_ack=0, 5 back-to-back requests at addrs 0..4 with DEPTH=4. Required: first 4 accepted, de_ack low after the 4th. Then pulse mem_ack once: de_ack high the next cycle, addr 4 accepted. Drain order is 0,1,2,3,4.
- Merge: mem_ack=0, write addr 7 nbyte 1110 data 0x11, then addr 9 nbyte 1110 data 0x22, then addr 9 nbyte 1101 data 0x3300. Required: count=2. Drain shows entry addr 9, nbyte 1100, data lanes [1:0]=0x33,0x22. With MERGE=0, count=3.
- No-merge into head: one entry addr 5 queued, second write addr 5 with a different lane. Required: count=2, head unchanged.
- Discard and simultaneous push/pop: a nbyte 1111 request is acked with count unchanged. A push on the same edge as mem_ack at count=2 leaves count=2 and preserves FIFO order.
- Async reset mid-burst with count=3: rst asserted between edges. Required: mem_req=0, idle=1, de_ack=1 immediately, without waiting for a clock edge.
